// File: rtl/mgmt_arbiter.sv
// Round-robin arbiter sharing the single-master management bus between NREQ requesters.
// Serialises accesses, enforces a 2-cycle request gap, and errors out unacknowledged accesses.
module mgmt_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      m_req,
    input  logic [NREQ*32-1:0]   m_adr,
    input  logic [NREQ-1:0]      m_rwn,
    input  logic [NREQ*2-1:0]    m_wen,
    input  logic [NREQ*32-1:0]   m_txd,
    output logic [NREQ-1:0]      m_ack,
    output logic [NREQ-1:0]      m_err,
    output logic                 m_rxe,
    output logic [31:0]          m_rxd,
    output logic                 mgmt_req,
    output logic [31:0]          mgmt_adr,
    output logic                 mgmt_rwn,
    output logic [1:0]           mgmt_wen,
    output logic [31:0]          mgmt_txd,
    input  logic                 mgmt_ack,
    input  logic                 mgmt_rxe,
    input  logic [31:0]          mgmt_rxd,
    output logic [1:0]           owner,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              gap_q, gap_d;
    logic              mgmt_req_q, mgmt_req_d;
    logic [31:0]       mgmt_adr_q, mgmt_adr_d;
    logic              mgmt_rwn_q, mgmt_rwn_d;
    logic [1:0]        mgmt_wen_q, mgmt_wen_d;
    logic [31:0]       mgmt_txd_q, mgmt_txd_d;
    logic [NREQ-1:0]   m_ack_q, m_ack_d;
    logic [NREQ-1:0]   m_err_q, m_err_d;
    logic              m_rxe_q, m_rxe_d;
    logic [31:0]       m_rxd_q, m_rxd_d;

    logic              found;
    int unsigned       gnt;

    // first pending request at or above ptr, wrapping
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        gnt   = 0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!found && m_req[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        mgmt_req_d = mgmt_req_q;
        mgmt_adr_d = mgmt_adr_q;
        mgmt_rwn_d = mgmt_rwn_q;
        mgmt_wen_d = mgmt_wen_q;
        mgmt_txd_d = mgmt_txd_q;
        m_ack_d    = '0;
        m_err_d    = '0;
        m_rxe_d    = 1'b0;
        m_rxd_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d    = 2'(gnt);
                    mgmt_adr_d = m_adr[32*gnt +: 32];
                    mgmt_rwn_d = m_rwn[gnt];
                    mgmt_wen_d = m_wen[2*gnt +: 2];
                    mgmt_txd_d = m_txd[32*gnt +: 32];
                    mgmt_req_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                // counter passed TIMEOUT-1 in the previous cycle, so m_err lands TIMEOUT+1 after mgmt_req rises
                if (mgmt_ack || cnt_q == 8'(TIMEOUT)) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        m_ack_d[i] = mgmt_ack && (32'(owner_q) == i);
                        m_err_d[i] = !mgmt_ack && (32'(owner_q) == i);
                    end
                    m_rxe_d    = mgmt_ack && mgmt_rxe;
                    m_rxd_d    = mgmt_ack ? mgmt_rxd : '0;
                    mgmt_req_d = 1'b0;
                    gap_d      = 1'b0;
                    ptr_d      = 2'((32'(owner_q) + 1) % NREQ);
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                gap_d = 1'b1;
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            gap_q      <= 1'b0;
            mgmt_req_q <= 1'b0;
            mgmt_adr_q <= '0;
            mgmt_rwn_q <= 1'b0;
            mgmt_wen_q <= '0;
            mgmt_txd_q <= '0;
            m_ack_q    <= '0;
            m_err_q    <= '0;
            m_rxe_q    <= 1'b0;
            m_rxd_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            mgmt_req_q <= mgmt_req_d;
            mgmt_adr_q <= mgmt_adr_d;
            mgmt_rwn_q <= mgmt_rwn_d;
            mgmt_wen_q <= mgmt_wen_d;
            mgmt_txd_q <= mgmt_txd_d;
            m_ack_q    <= m_ack_d;
            m_err_q    <= m_err_d;
            m_rxe_q    <= m_rxe_d;
            m_rxd_q    <= m_rxd_d;
        end
    end

    assign m_ack    = m_ack_q;
    assign m_err    = m_err_q;
    assign m_rxe    = m_rxe_q;
    assign m_rxd    = m_rxd_q;
    assign mgmt_req = mgmt_req_q;
    assign mgmt_adr = mgmt_adr_q;
    assign mgmt_rwn = mgmt_rwn_q;
    assign mgmt_wen = mgmt_wen_q;
    assign mgmt_txd = mgmt_txd_q;
    assign owner    = owner_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mgmt_arbiter.sv
// Bench for mgmt_arbiter: directed scenarios plus random traffic against a
// transaction-timing reference model (grant time, age since grant, response time).
module tb_mgmt_arbiter;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     m_req;
    logic [NREQ*32-1:0]  m_adr;
    logic [NREQ-1:0]     m_rwn;
    logic [NREQ*2-1:0]   m_wen;
    logic [NREQ*32-1:0]  m_txd;
    logic [NREQ-1:0]     m_ack;
    logic [NREQ-1:0]     m_err;
    logic                m_rxe;
    logic [31:0]         m_rxd;
    logic                mgmt_req;
    logic [31:0]         mgmt_adr;
    logic                mgmt_rwn;
    logic [1:0]          mgmt_wen;
    logic [31:0]         mgmt_txd;
    logic                mgmt_ack;
    logic                mgmt_rxe;
    logic [31:0]         mgmt_rxd;
    logic [1:0]          owner;
    logic                busy;

    always #5 clk = ~clk;

    mgmt_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_adr(m_adr), .m_rwn(m_rwn), .m_wen(m_wen), .m_txd(m_txd),
        .m_ack(m_ack), .m_err(m_err), .m_rxe(m_rxe), .m_rxd(m_rxd),
        .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_rwn(mgmt_rwn),
        .mgmt_wen(mgmt_wen), .mgmt_txd(mgmt_txd),
        .mgmt_ack(mgmt_ack), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd),
        .owner(owner), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: an access is described by its first mgmt_req cycle and its response cycle
    bit              e_inflight;
    int              e_start;
    int              e_done;
    int unsigned     e_ptr;
    logic [1:0]      e_owner;
    logic            e_mreq, e_rwn, e_rxe, e_busy;
    logic [31:0]     e_adr, e_txd, e_rxd;
    logic [1:0]      e_wen;
    logic [NREQ-1:0] e_ack, e_err;

    // reactive slave and requester behaviour
    bit          slv_auto, slv_rand, auto_drop;
    int          slv_lat, slv_cnt;
    logic [31:0] slv_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_close();
        e_inflight = 1'b0;
        e_done     = cyc + 1;
        e_ptr      = (32'(e_owner) + 1) % NREQ;
    endtask

    task automatic model_step();
        int unsigned idx;
        bit          got;
        e_ack = '0; e_err = '0; e_rxe = 1'b0; e_rxd = '0;
        if (rst) begin
            e_inflight = 1'b0; e_done = -100; e_ptr = 0; e_owner = '0;
            e_adr = '0; e_rwn = 1'b0; e_wen = '0; e_txd = '0;
        end else if (e_inflight) begin
            if (mgmt_ack) begin
                e_ack = NREQ'(1) << e_owner;
                e_rxe = mgmt_rxe;
                e_rxd = mgmt_rxd;
                model_close();
            end else if (cyc - e_start == int'(TIMEOUT)) begin
                e_err = NREQ'(1) << e_owner;
                model_close();
            end
        end else if (cyc >= e_done + 2) begin
            got = 1'b0;
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (e_ptr + k) % NREQ;
                if (!got && m_req[idx]) begin
                    got        = 1'b1;
                    e_owner    = 2'(idx);
                    e_adr      = m_adr[32*idx +: 32];
                    e_rwn      = m_rwn[idx];
                    e_wen      = m_wen[2*idx +: 2];
                    e_txd      = m_txd[32*idx +: 32];
                    e_inflight = 1'b1;
                    e_start    = cyc + 1;
                end
            end
        end
        e_mreq = e_inflight;
        e_busy = e_inflight || (cyc + 1 <= e_done + 1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("owner", 32'(owner), 32'(e_owner));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("mgmt_req", 32'(mgmt_req), 32'(e_mreq));
        chk("mgmt_adr", mgmt_adr, e_adr);
        chk("mgmt_rwn", 32'(mgmt_rwn), 32'(e_rwn));
        chk("mgmt_wen", 32'(mgmt_wen), 32'(e_wen));
        chk("mgmt_txd", mgmt_txd, e_txd);
        chk("m_ack", 32'(m_ack), 32'(e_ack));
        chk("m_err", 32'(m_err), 32'(e_err));
        chk("m_rxe", 32'(m_rxe), 32'(e_rxe));
        chk("m_rxd", m_rxd, e_rxd);
        if (slv_auto) begin
            if (mgmt_req) begin
                slv_cnt++;
                if (slv_rand && slv_cnt == 1) slv_lat = int'($urandom_range(0, 20));
            end else begin
                slv_cnt = 0;
            end
            mgmt_ack = mgmt_req ? (slv_lat >= 0 && slv_cnt == slv_lat + 1)
                                : (slv_rand && $urandom_range(0, 7) == 0);
            mgmt_rxe = mgmt_ack && (mgmt_rwn || !mgmt_req);
            mgmt_rxd = mgmt_ack ? (slv_rand ? $urandom() : slv_data) : $urandom();
        end
        if (auto_drop) m_req = m_req & ~(m_ack | m_err);
    endtask

    task automatic do_reset();
        rst = 1'b1; m_req = '0; tick(); tick(); rst = 1'b0;
    endtask

    initial begin
        int c0, ack_at, err_at, rise_at, req_hi;
        logic prev_req;
        int rises[$];
        int rise_own[$];

        rst = 1'b1; m_req = '0; m_adr = '0; m_rwn = '0; m_wen = '0; m_txd = '0;
        mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
        slv_auto = 1'b1; slv_rand = 1'b0; auto_drop = 1'b1; slv_lat = 2; slv_cnt = 0;
        slv_data = 32'hDEADBEEF;
        e_inflight = 1'b0; e_done = -100; e_ptr = 0; e_start = 0;

        // reset state
        tick(); tick();
        rst = 1'b0;
        tick();

        // single read from requester 0
        m_adr[31:0] = 32'h0000_0010; m_rwn[0] = 1'b1; m_req[0] = 1'b1;
        c0 = cyc; ack_at = -1; req_hi = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mgmt_req) req_hi++;
            if (m_ack[0]) begin
                ack_at = cyc;
                chk("t1_rxd", m_rxd, 32'hDEADBEEF);
                chk("t1_rxe", 32'(m_rxe), 32'd1);
            end
        end
        chk("t1_ack_latency", 32'(ack_at - c0), 32'd4);
        chk("t1_req_cycles", 32'(req_hi), 32'd3);

        // continuous requests from both: alternating grants, 6-cycle period
        do_reset();
        auto_drop = 1'b0; slv_data = 32'h0BAD_F00D;
        m_req = '1; prev_req = 1'b0;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (mgmt_req && !prev_req) begin
                rises.push_back(cyc);
                rise_own.push_back(int'(owner));
            end
            prev_req = mgmt_req;
        end
        chk("t2_nrises", 32'(rises.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < rises.size(); i++) begin
            chk("t2_grant_order", 32'(rise_own[i]), 32'(i % 2));
            if (i > 0) chk("t2_period", 32'(rises[i] - rises[i-1]), 32'd6);
        end
        m_req = '0; auto_drop = 1'b1;

        // write from requester 1 while requester 0 churns its address
        do_reset();
        m_adr[63:32] = 32'hA000_0040; m_rwn[1] = 1'b0; m_wen[3:2] = 2'b01;
        m_txd[63:32] = 32'h1234_5678; m_req = 2'b10;
        for (int i = 0; i < 10; i++) begin
            m_adr[31:0] = $urandom();
            m_txd[31:0] = $urandom();
            tick();
            if (mgmt_req) begin
                chk("t3_adr", mgmt_adr, 32'hA000_0040);
                chk("t3_wen", 32'(mgmt_wen), 32'd1);
                chk("t3_txd", mgmt_txd, 32'h1234_5678);
            end
            if (m_ack[1]) chk("t3_rxe", 32'(m_rxe), 32'd0);
        end

        // timeout with no slave ack
        do_reset();
        slv_lat = -1; m_req = 2'b01; prev_req = 1'b0; rise_at = -1; err_at = -1;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (mgmt_req && !prev_req) rise_at = cyc;
            if (m_err[0]) err_at = cyc;
            prev_req = mgmt_req;
        end
        chk("t4_err_delay", 32'(err_at - rise_at), 32'(TIMEOUT + 1));

        // ack at counter=15 and in the expiry cycle both complete as acks
        for (int l = 15; l <= 16; l++) begin
            do_reset();
            slv_lat = l; m_req = 2'b01; ack_at = -1; err_at = -1;
            for (int i = 0; i < 24; i++) begin
                tick();
                if (m_ack[0]) ack_at = cyc;
                if (m_err[0]) err_at = cyc;
            end
            chk("t4_late_ack_seen", 32'(ack_at > 0), 32'd1);
            chk("t4_late_no_err", 32'(err_at), 32'hFFFF_FFFF);
        end

        // reset in the second BUSY cycle
        do_reset();
        slv_lat = -1; m_req = 2'b10;
        for (int i = 0; i < 5 && !mgmt_req; i++) tick();
        chk("t5_granted", 32'(mgmt_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_req_low", 32'(mgmt_req), 32'd0);
        chk("t5_no_pulse", 32'(m_ack | m_err), 32'd0);
        slv_lat = 2; m_req = 2'b11;
        tick();
        chk("t5_first_owner", 32'(owner), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        m_req = '0;
        for (int i = 0; i < 8; i++) tick();

        // spurious slave strobes in IDLE and GAP
        do_reset();
        slv_auto = 1'b0;
        mgmt_ack = 1'b1; mgmt_rxe = 1'b1; mgmt_rxd = 32'h5555_AAAA;
        tick(); tick();
        chk("t6_idle_no_ack", 32'(m_ack), 32'd0);
        mgmt_ack = 1'b0; mgmt_rxe = 1'b0;
        slv_auto = 1'b1; slv_lat = 1; m_req = 2'b01;
        for (int i = 0; i < 12 && !m_ack[0]; i++) tick();
        chk("t6_real_ack", 32'(m_ack), 32'd1);
        slv_auto = 1'b0;
        mgmt_ack = 1'b1; mgmt_rxe = 1'b1;
        tick(); tick();
        chk("t6_gap_no_ack", 32'(m_ack), 32'd0);
        mgmt_ack = 1'b0; mgmt_rxe = 1'b0;
        tick(); tick();

        // random traffic
        slv_auto = 1'b1; slv_rand = 1'b1; slv_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                if (!m_req[r]) begin
                    m_adr[32*r +: 32] = $urandom();
                    m_txd[32*r +: 32] = $urandom();
                    m_rwn[r]          = 1'($urandom());
                    m_wen[2*r +: 2]   = 2'($urandom());
                    if ($urandom_range(0, 3) == 0) m_req[r] = 1'b1;
                end
            end
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
